alkmdseq: RTL and testbench

Multiply/divide step sequencer for the DC615 ALK. Sits directly upstream of the Q shift-in/out routing. It counts iterations for MUL and DIV microinstructions and issues the per-cycle Q shift direction (`dq_q_shl_h` / `dq_q_shr_h`). It also generates the bit shifted into Q (`q_sin_h`) and the ALU add/subtract/pass selection. For DIV it runs a non-restoring division and, optionally, a final remainder-correction cycle.

---
 rtl/alkmdseq_pkg.sv | 31 +++
 rtl/alkmdseq_if.sv | 30 +++
 rtl/alkmdseq_cnt.sv | 39 +++
 rtl/alkmdseq.sv | 108 ++++++++++
 tb/tb_alkmdseq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alkmdseq_pkg.sv
// Shared definitions for the ALK multiply/divide step sequencer:
// FSM states, ALU operation codes and DSIZE step-count decode.
package alk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Counter load values are N-1 so the step taken at count 0 is the last.
    localparam logic [4:0] STEPS_BYTE_M1 = 5'd7;
    localparam logic [4:0] STEPS_WORD_M1 = 5'd15;
    localparam logic [4:0] STEPS_LONG_M1 = 5'd31;

    function automatic logic [4:0] dsize_to_last(input logic [1:0] dsize_h);
        logic [4:0] last;
        case (dsize_h)
            2'b00:   last = STEPS_BYTE_M1;
            2'b01:   last = STEPS_WORD_M1;
            default: last = STEPS_LONG_M1;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/alkmdseq_if.sv
// Microcode/datapath-facing signal bundle of the multiply/divide sequencer.
// The sequencer is the slave; the microcode and ALU/Q datapath form the master.
interface alkmdseq_if;

    logic       start_h;
    logic       op_div_h;
    logic [1:0] dsize_l;
    logic       hold_l;
    logic       alu_cout_h;
    logic       alu_sout_h;
    logic       q_sout_shr_h;

    logic       dq_q_shl_h;
    logic       dq_q_shr_h;
    logic       q_sin_h;
    logic [1:0] alu_op_h;
    logic       busy_h;
    logic       done_h;

    modport master (
        output start_h, op_div_h, dsize_l, hold_l, alu_cout_h, alu_sout_h, q_sout_shr_h,
        input  dq_q_shl_h, dq_q_shr_h, q_sin_h, alu_op_h, busy_h, done_h
    );

    modport slave (
        input  start_h, op_div_h, dsize_l, hold_l, alu_cout_h, alu_sout_h, q_sout_shr_h,
        output dq_q_shl_h, dq_q_shr_h, q_sin_h, alu_op_h, busy_h, done_h
    );

endinterface

// File: rtl/alkmdseq_cnt.sv
// Loadable iteration down-counter with hold; tc_o flags the final step.
// Load takes priority over decrement, and the count never wraps below zero.
module alkmdcnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_l,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             hold_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/alkmdseq.sv
// Multiply/divide step sequencer: drives Q shift direction, Q shift-in bit and ALU op.
// Define ALKMDSEQ_REM_FIXUP_EN to add the restoring FIXUP cycle after a DIV.
module alkmdseq
    import alk_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic        clk_h,
    input  logic        reset_l,
    alkmdseq_if.slave   bus
);

    seq_state_e state_q;
    logic       op_div_q;
    logic       sub_next_q;
    logic       cnt_tc;
    logic       cnt_load;

    assign cnt_load = (state_q == ST_IDLE) && bus.start_h;

    alkmdcnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_h      (clk_h),
        .reset_l    (reset_l),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(dsize_to_last(~bus.dsize_l))),
        .dec_i      (state_q == ST_STEP),
        .hold_i     (!bus.hold_l),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            op_div_q   <= 1'b0;
            sub_next_q <= 1'b0;
        end else if (bus.hold_l) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_h) begin
                        op_div_q   <= bus.op_div_h;
                        sub_next_q <= 1'b1;
                        state_q    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // Non-restoring divide: carry-out picks the next step's add/subtract.
                    if (op_div_q) begin
                        sub_next_q <= bus.alu_cout_h;
                    end
                    if (cnt_tc) begin
`ifdef ALKMDSEQ_REM_FIXUP_EN
                        if (op_div_q && !bus.alu_cout_h) begin
                            state_q <= ST_FIXUP;
                        end else begin
                            state_q <= ST_DONE;
                        end
`else
                        state_q <= ST_DONE;
`endif
                    end
                end
`ifdef ALKMDSEQ_REM_FIXUP_EN
                ST_FIXUP: state_q <= ST_DONE;
`endif
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Q shift enables are gated by hold so a stalled step never shifts Q.
    always_comb begin
        bus.dq_q_shl_h = 1'b0;
        bus.dq_q_shr_h = 1'b0;
        bus.q_sin_h    = 1'b0;
        bus.alu_op_h   = ALU_PASS;
        bus.busy_h     = 1'b0;
        bus.done_h     = 1'b0;
        case (state_q)
            ST_STEP: begin
                bus.busy_h = 1'b1;
                if (op_div_q) begin
                    bus.dq_q_shl_h = bus.hold_l;
                    bus.q_sin_h    = bus.alu_cout_h;
                    bus.alu_op_h   = sub_next_q ? ALU_SUB : ALU_ADD;
                end else begin
                    bus.dq_q_shr_h = bus.hold_l;
                    bus.q_sin_h    = bus.alu_sout_h;
                    bus.alu_op_h   = bus.q_sout_shr_h ? ALU_ADD : ALU_PASS;
                end
            end
`ifdef ALKMDSEQ_REM_FIXUP_EN
            ST_FIXUP: begin
                bus.busy_h   = 1'b1;
                bus.alu_op_h = ALU_ADD;
            end
`endif
            ST_DONE: begin
                bus.done_h = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alkmdseq.sv
// Directed testbench for alkmdseq: MUL, DIV (with/without fixup), hold, reset and restart.
module tb_alkmdseq;

    logic clk_h;
    logic reset_l;
    int   vecs;
    int   errs;

    alkmdseq_if bus ();

    alkmdseq #(
        .CNT_W (6)
    ) dut (
        .clk_h   (clk_h),
        .reset_l (reset_l),
        .bus     (bus.slave)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    // {shl, shr, q_sin, alu_op[1:0], busy, done}
    function automatic logic [6:0] ex(input logic shl, input logic shr, input logic sin,
                                      input logic [1:0] op, input logic busy, input logic done);
        return {shl, shr, sin, op, busy, done};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.dq_q_shl_h, bus.dq_q_shr_h, bus.q_sin_h, bus.alu_op_h, bus.busy_h, bus.done_h};
    endfunction

    task automatic chk(input string tag, input logic [6:0] expv);
        logic [6:0] o;
        o = obs();
        vecs++;
        assert (o === expv) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, o, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int expv);
        vecs++;
        assert (o === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic start_seq(input logic div, input logic [1:0] dsl);
        bus.start_h  = 1'b1;
        bus.op_div_h = div;
        bus.dsize_l  = dsl;
        tick();
        bus.start_h  = 1'b0;
    endtask

    localparam logic [1:0] PS = 2'b00;
    localparam logic [1:0] AD = 2'b01;
    localparam logic [1:0] SB = 2'b10;

    initial begin
        logic [15:0] mq;
        logic [15:0] ms;
        logic [15:0] wc;
        logic        prev;
        logic        held;
        int          shifts;

        vecs = 0;
        errs = 0;
        reset_l          = 1'b0;
        bus.start_h      = 1'b0;
        bus.op_div_h     = 1'b0;
        bus.dsize_l      = 2'b11;
        bus.hold_l       = 1'b1;
        bus.alu_cout_h   = 1'b1;
        bus.alu_sout_h   = 1'b1;
        bus.q_sout_shr_h = 1'b1;

        // Reset state, with ALU/Q inputs high so any leakage would show.
        #2;
        chk("reset_outputs", ex(0, 0, 0, PS, 0, 0));
        tick();
        tick();
        reset_l = 1'b1;
        tick();
        #1;
        chk("idle_no_start", ex(0, 0, 0, PS, 0, 0));
        $display("seq reset: done");

        // MUL byte
        mq = 16'b0000_0000_1011_0010;
        ms = 16'b0000_0000_0110_1001;
        start_seq(1'b0, 2'b11);
        for (int k = 0; k < 8; k++) begin
            bus.q_sout_shr_h = mq[k];
            bus.alu_sout_h   = ms[k];
            #1;
            chk($sformatf("mul_byte_step%0d", k + 1), ex(0, 1, ms[k], mq[k] ? AD : PS, 1, 0));
            tick();
        end
        #1;
        chk("mul_byte_done_c9", ex(0, 0, 0, PS, 0, 1));
        tick();
        #1;
        chk("mul_byte_idle_c10", ex(0, 0, 0, PS, 0, 0));
        $display("seq mul byte: done");

        // DIV long, every carry-out 1
        bus.alu_cout_h = 1'b1;
        start_seq(1'b1, 2'b00);
        for (int k = 0; k < 32; k++) begin
            #1;
            chk($sformatf("div_long_step%0d", k + 1), ex(1, 0, 1, SB, 1, 0));
            tick();
        end
        #1;
        chk("div_long_done_c33", ex(0, 0, 0, PS, 0, 1));
        tick();
        $display("seq div long: done");

        // DIV word, carry-out 0 at step 3 and at the last step
        wc   = 16'h7FFB;
        prev = 1'b1;
        start_seq(1'b1, 2'b10);
        for (int k = 0; k < 16; k++) begin
            bus.alu_cout_h = wc[k];
            #1;
            chk($sformatf("div_word_step%0d", k + 1), ex(1, 0, wc[k], prev ? SB : AD, 1, 0));
            prev = wc[k];
            tick();
        end
        bus.alu_cout_h = 1'b0;
`ifdef ALKMDSEQ_REM_FIXUP_EN
        #1;
        chk("div_word_fixup_c17", ex(0, 0, 0, AD, 1, 0));
        tick();
        #1;
        chk("div_word_done_c18", ex(0, 0, 0, PS, 0, 1));
`else
        #1;
        chk("div_word_done_c17", ex(0, 0, 0, PS, 0, 1));
`endif
        tick();
        #1;
        chk("div_word_idle", ex(0, 0, 0, PS, 0, 0));
        $display("seq div word: done");

        // MUL byte with a 3-cycle hold in cycles 4..6
        mq = 16'b0000_0101_1100_1010;
        ms = 16'b0000_0011_0101_0110;
        shifts = 0;
        start_seq(1'b0, 2'b11);
        for (int c = 1; c <= 11; c++) begin
            held = (c >= 4) && (c <= 6);
            bus.hold_l       = ~held;
            bus.q_sout_shr_h = mq[c-1];
            bus.alu_sout_h   = ms[c-1];
            #1;
            shifts += int'(bus.dq_q_shr_h);
            chk($sformatf("mul_hold_c%0d", c), ex(0, ~held, ms[c-1], mq[c-1] ? AD : PS, 1, 0));
            tick();
        end
        bus.hold_l = 1'b1;
        #1;
        chk("mul_hold_done_c12", ex(0, 0, 0, PS, 0, 1));
        chk_int("mul_hold_shift_count", shifts, 8);
        tick();
        $display("seq mul hold: done");

        // DIV byte interrupted by reset at step 5
        bus.alu_cout_h = 1'b1;
        start_seq(1'b1, 2'b11);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("div_rst_step%0d", k + 1), ex(1, 0, 1, SB, 1, 0));
            if (k < 4) tick();
        end
        reset_l = 1'b0;
        #1;
        chk("div_rst_async_zero", ex(0, 0, 0, PS, 0, 0));
        tick();
        #1;
        chk("div_rst_held_zero", ex(0, 0, 0, PS, 0, 0));
        reset_l = 1'b1;
        tick();
        #1;
        chk("div_rst_release_idle", ex(0, 0, 0, PS, 0, 0));
        $display("seq reset mid-div: done");

        // Restart: full 8 steps, start pulses in STEP and DONE ignored
        start_seq(1'b1, 2'b11);
        for (int k = 0; k < 8; k++) begin
            bus.start_h = (k == 2);
            #1;
            chk($sformatf("restart_step%0d", k + 1), ex(1, 0, 1, SB, 1, 0));
            tick();
        end
        bus.start_h = 1'b1;
        #1;
        chk("restart_done_c9", ex(0, 0, 0, PS, 0, 1));
        tick();
        bus.start_h = 1'b0;
        #1;
        chk("restart_idle_c10", ex(0, 0, 0, PS, 0, 0));
        tick();
        #1;
        chk("restart_idle_c11", ex(0, 0, 0, PS, 0, 0));
        $display("seq restart: done");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
